gray_rx_decode: RTL

Consumes a Gray-coded bus driven from another clock domain, typically a Gray counter or a bin-to-Gray encoder output. Synchronizes the bus into the local clock and decodes it back to binary. Reports each value change as a one-cycle valid pulse carrying the signed-modular step size. Flags any sample whose Gray code changed in more than one bit, since that violates the single-bit-change guarantee.

---
 rtl/gray_rx_decode_if.sv | 23 ++
 rtl/gray_rx_decode.sv | 139 +++++++++++++
 2 files changed

// File: rtl/gray_rx_decode_if.sv
// Bus bundle for gray_rx_decode: remote Gray input, clear, and the decoded
// value/step/error outputs.
interface gray_rx_decode_if #(
    parameter int LEN = 4
);
    logic [LEN-1:0] i_gray;
    logic           i_clr;
    logic [LEN-1:0] o_bin;
    logic           o_valid;
    logic [LEN-1:0] o_delta;
    logic           o_err;
    logic [7:0]     o_err_cnt;

    modport master (
        output i_gray, i_clr,
        input  o_bin, o_valid, o_delta, o_err, o_err_cnt
    );

    modport slave (
        input  i_gray, i_clr,
        output o_bin, o_valid, o_delta, o_err, o_err_cnt
    );
endinterface

// File: rtl/gray_rx_decode.sv
// Synchronizes a Gray-coded bus from a foreign clock domain, decodes it to
// binary and reports each change with its modular step and a multi-bit error flag.
//
// state    | meaning
// ST_PRIME | sync chain filling; g_prev/o_bin track the input, no pulses or errors
// ST_RUN   | primed; each change of sync_g produces one o_valid pulse
module gray_rx_decode #(
    parameter int LEN         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    gray_rx_decode_if.slave bus
);
    typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(SYNC_STAGES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] prime_cnt, prime_cnt_nxt;
    logic             primed;

    logic [LEN-1:0] sync_s [SYNC_STAGES];
    logic [LEN-1:0] sync_g;
    logic [LEN-1:0] g_prev;
    logic [LEN-1:0] bin_q;
    logic [LEN-1:0] delta_q;
    logic           valid_q;
    logic           err_q;
    logic [7:0]     err_cnt_q;

    logic [LEN-1:0] dec;
    logic [LEN-1:0] diff;
    logic           changed;
    logic           multi;
    logic           accept;
    logic           new_err;

    function automatic logic [LEN-1:0] gray2bin(input logic [LEN-1:0] g);
        logic [LEN-1:0] b;
        b          = '0;
        b[LEN-1]   = g[LEN-1];
        for (int i = LEN - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
        end
    end

    // Priming lasts SYNC_STAGES+1 cycles so g_prev holds a fully synchronized sample.
    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        case (state)
            ST_PRIME: begin
                if (prime_cnt == PRIME_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    prime_cnt_nxt = prime_cnt + 1'b1;
                end
            end
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_PRIME;
        endcase
    end

    assign primed = (state == ST_RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_s[k] <= '0;
            end
        end else begin
            sync_s[0] <= bus.i_gray;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_s[k] <= sync_s[k-1];
            end
        end
    end

    assign sync_g  = sync_s[SYNC_STAGES-1];
    assign dec     = gray2bin(sync_g);
    assign diff    = sync_g ^ g_prev;
    assign changed = |diff;
    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multi   = changed && (|(diff & (diff - 1'b1)));
    assign accept  = primed && changed;
    assign new_err = accept && multi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            g_prev    <= '0;
            bin_q     <= '0;
            delta_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            valid_q <= accept;
            if (!primed) begin
                g_prev <= sync_g;
                bin_q  <= dec;
            end else if (changed) begin
                g_prev  <= sync_g;
                bin_q   <= dec;
                delta_q <= dec - bin_q;
            end

            if (new_err) begin
                err_q <= 1'b1;
                if (bus.i_clr) begin
                    err_cnt_q <= 8'd1;
                end else if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end else if (bus.i_clr) begin
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end
        end
    end

    assign bus.o_bin     = bin_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_delta   = delta_q;
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = err_cnt_q;
endmodule
